// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port lane-masked SRAM model.
package sram_pkg;

  typedef enum logic {INIT, RUN} state_t;

  // Widest word the mask helper can expand.
  localparam int MAX_W = 1024;

  function automatic int lanes(input int data_w, input int mask_gran);
    return data_w / mask_gran;
  endfunction

  // Active-low per-lane enables become an active-high per-bit write mask.
  function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_W-1:0] bwen,
                                                   input int              mask_gran);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_W; b++) m[b] = ~bwen[b / mask_gran];
    return m;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Zero-init sequencer: walks the array once after reset, then hands the write port to the user.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
      // READY trails RUN by one edge, so it rises the edge after the last zero write.
      ready <= (state == RUN);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    if (state == INIT) begin
      if (cnt == LAST) next_state = RUN;
      else             cnt_nxt    = cnt + 1'b1;
    end
  end

  always_comb begin
    init_we   = (state == INIT);
    init_addr = cnt;
  end

endmodule

// File: rtl/sram_1p_bw_init.sv
// Single-port SRAM model with lane-masked writes, hardware zero-init and a read-valid strobe.
// Define SRAM_PARITY_EN to store one even-parity bit per lane and flag mismatches on PERR.
module sram_1p_bw_init
  import sram_pkg::*;
#(
  parameter int  DATA_W    = 128,
  parameter int  DEPTH     = 64,
  parameter int  ADDR_W    = 6,
  parameter int  MASK_GRAN = 1,
  parameter int  OUT_REG   = 0,
  localparam int LANES     = lanes(DATA_W, MASK_GRAN)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [LANES-1:0]  BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              QVALID,
  output logic              READY,
  output logic              PERR
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic              ready, init_we;
  logic [ADDR_W-1:0] init_addr;

  sram_init_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init_ctrl (
    .clk      (CLK),
    .rst_n    (RST_N),
    .ready    (ready),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  assign READY = ready;

  logic in_range, rd_en, rd_err;
  assign in_range = ({1'b0, A} < DEPTH_X);
  assign rd_en    = ready & ~CEN & WEN;

  logic [MAX_W-1:0]  mask_full;
  logic [MAX_W-1:0]  unused_mask;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, wr_mask;

  assign mask_full   = expand_mask(MAX_W'(BWEN), MASK_GRAN);
  assign unused_mask = mask_full;

  // Init owns the write port until READY; out-of-range user writes are dropped.
  always_comb begin
    wr_en   = ready & ~CEN & ~WEN & in_range;
    wr_addr = A;
    wr_data = D;
    wr_mask = mask_full[DATA_W-1:0];
    if (init_we) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_data = '0;
      wr_mask = '1;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the init sequence clears it one word per cycle instead.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  logic [DATA_W-1:0] rd_word;
  assign rd_word = in_range ? mem[A] : '0;

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wr_par, wr_lane, rd_calc, rd_par;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wr_par[l]  = ^wr_data[l*MASK_GRAN +: MASK_GRAN];
      wr_lane[l] = init_we | ~BWEN[l];
      rd_calc[l] = ^rd_word[l*MASK_GRAN +: MASK_GRAN];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) par_mem[wr_addr] <= (par_mem[wr_addr] & ~wr_lane) | (wr_par & wr_lane);
  end

  assign rd_par = in_range ? par_mem[A] : '0;
  assign rd_err = in_range & |(rd_calc ^ rd_par);
`else
  assign rd_err = 1'b0;
`endif

  logic [DATA_W-1:0] s1_q;
  logic              s1_v, s1_p;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= '0;
      s1_v <= 1'b0;
      s1_p <= 1'b0;
    end else begin
      s1_v <= rd_en;
      s1_p <= rd_en & rd_err;
      if (rd_en) s1_q <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_q;
      logic              s2_v, s2_p;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s2_q <= '0;
          s2_v <= 1'b0;
          s2_p <= 1'b0;
        end else begin
          s2_v <= s1_v;
          s2_p <= s1_p;
          if (s1_v) s2_q <= s1_q;
        end
      end

      assign Q      = s2_q;
      assign QVALID = s2_v;
      assign PERR   = s2_p;
    end else begin : g_no_out_reg
      assign Q      = s1_q;
      assign QVALID = s1_v;
      assign PERR   = s1_p;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1p_bw_init.sv
// Bench for sram_1p_bw_init: two instances (bit mask / latency 1 / depth 64 and
// byte mask / latency 2 / depth 48) share stimulus and are checked against an array model.
module tb_sram_1p_bw_init;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 6;
  localparam int LANES0 = 128;
  localparam int LANES1 = 16;
  localparam int NK     = 2;
`ifdef SRAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              CEN = 1'b1;
  logic              WEN = 1'b1;
  logic [ADDR_W-1:0] A = '0;
  logic [DATA_W-1:0] D = '0;
  logic [LANES0-1:0] BWEN0 = '1;
  logic [LANES1-1:0] BWEN1 = '1;

  logic [DATA_W-1:0] q0, q1;
  logic              qv0, qv1, rdy0, rdy1, pe0, pe1;

  always #5 CLK = ~CLK;

  sram_1p_bw_init #(.DATA_W(DATA_W), .DEPTH(64), .ADDR_W(ADDR_W), .MASK_GRAN(1), .OUT_REG(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .CEN(CEN), .WEN(WEN), .BWEN(BWEN0), .A(A), .D(D),
    .Q(q0), .QVALID(qv0), .READY(rdy0), .PERR(pe0)
  );

  sram_1p_bw_init #(.DATA_W(DATA_W), .DEPTH(48), .ADDR_W(ADDR_W), .MASK_GRAN(8), .OUT_REG(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .CEN(CEN), .WEN(WEN), .BWEN(BWEN1), .A(A), .D(D),
    .Q(q1), .QVALID(qv1), .READY(rdy1), .PERR(pe1)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 64 : 48;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Behavioural model: contents, corrupted-parity lanes, readiness and a read delay line.
  logic [DATA_W-1:0] mm   [NK][64];
  logic [127:0]      corr [NK][64];
  int                init_edges [NK];
  bit                m_ready [NK];
  logic [DATA_W-1:0] m_q [NK];
  bit                m_qv [NK];
  bit                m_pe [NK];
  bit                pv [NK];
  logic [DATA_W-1:0] pd [NK];
  bit                pp [NK];

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int a = 0; a < 64; a++) begin
        mm[k][a]   = '0;
        corr[k][a] = '0;
      end
      init_edges[k] = 0;
      m_ready[k]    = 1'b0;
      m_q[k]        = '0;
      m_qv[k]       = 1'b0;
      m_pe[k]       = 1'b0;
      pv[k]         = 1'b0;
      pd[k]         = '0;
      pp[k]         = 1'b0;
    end
  endtask

  task automatic present(input int k, input bit v, input logic [DATA_W-1:0] d, input bit p);
    m_qv[k] = v;
    m_pe[k] = v & p;
    if (v) m_q[k] = d;
  endtask

  task automatic model_step(input int k);
    bit                ev, ep, off;
    logic [DATA_W-1:0] ed;
    int                lane;
    ev = 1'b0;
    ep = 1'b0;
    ed = '0;
    if (m_ready[k] && !CEN) begin
      if (!WEN) begin
        if (int'(A) < depth_of(k)) begin
          for (int b = 0; b < DATA_W; b++) begin
            lane = (k == 0) ? b : b / 8;
            off  = (k == 0) ? BWEN0[b] : BWEN1[b/8];
            if (!off) begin
              mm[k][A][b]      = D[b];
              corr[k][A][lane] = 1'b0;
            end
          end
        end
      end else begin
        ev = 1'b1;
        if (int'(A) < depth_of(k)) begin
          ed = mm[k][A];
          ep = PAR_ON && (corr[k][A] != '0);
        end
      end
    end
    if (!m_ready[k]) begin
      init_edges[k]++;
      if (init_edges[k] == depth_of(k) + 1) m_ready[k] = 1'b1;
    end
    if (lat_of(k) == 1) begin
      present(k, ev, ed, ep);
    end else begin
      present(k, pv[k], pd[k], pp[k]);
      pv[k] = ev;
      pd[k] = ed;
      pp[k] = ep;
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else for (int k = 0; k < NK; k++) model_step(k);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (checking) begin
      check("ready0", rdy0, m_ready[0]);
      check("qvalid0", qv0, m_qv[0]);
      check("q0", q0, m_q[0]);
      check("perr0", pe0, m_pe[0]);
      check("ready1", rdy1, m_ready[1]);
      check("qvalid1", qv1, m_qv[1]);
      check("q1", q1, m_q[1]);
      check("perr1", pe1, m_pe[1]);
    end
  end

  task automatic drive(input logic cen, input logic wen, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [LANES0-1:0] b0,
                       input logic [LANES1-1:0] b1);
    @(negedge CLK);
    CEN   = cen;
    WEN   = wen;
    A     = a;
    D     = d;
    BWEN0 = b0;
    BWEN1 = b1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [LANES0-1:0] b0, input logic [LANES1-1:0] b1);
    drive(1'b0, 1'b0, a, d, b0, b1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    drive(1'b0, 1'b1, a, {4{$urandom}}, '1, '1);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, A, D, '1, '1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(rdy0 && rdy1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("ready_timeout", {rdy0, rdy1}, 2'b11);
  endtask

  logic [DATA_W-1:0] pat_a5;
  logic [DATA_W-1:0] rnd_d;

  initial begin
    pat_a5 = {16{8'hA5}};
    model_reset();
    #1 RST_N = 1'b0;
    #2 checking = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;

    // Init length: READY0 rises on edge 65, READY1 on edge 49.
    for (int e = 1; e <= 65; e++) begin
      @(negedge CLK);
      check("ready0_edge", rdy0, (e >= 65));
      check("ready1_edge", rdy1, (e >= 49));
    end

    // Every address reads back zero after init.
    for (int a = 0; a < 64; a++) do_read(ADDR_W'(a));
    idle();
    idle();
    check("init_zero_q0", q0, '0);
    check("init_zero_model", m_q[0], '0);

    // Only lane 0 enabled: 0xFF lands in the low byte.
    do_write(6'd5, '1, {{120{1'b1}}, 8'h00}, 16'hFFFE);
    do_read(6'd5);
    idle();
    check("lane0_qv0", qv0, 1'b1);
    check("lane0_q0", q0, 128'hFF);
    check("lane0_model", m_q[0], 128'hFF);
    idle();
    check("lane0_qv1", qv1, 1'b1);
    check("lane0_q1", q1, 128'hFF);
    check("lane0_qv0_drop", qv0, 1'b0);

    // Back-to-back reads 3,4,3.
    do_write(6'd3, pat_a5, '0, '0);
    do_read(6'd3);
    do_read(6'd4);
    check("b2b_q0_first", q0, pat_a5);
    do_read(6'd3);
    check("b2b_q0_second", q0, '0);
    check("b2b_q1_first", q1, pat_a5);
    idle();
    check("b2b_q0_third", q0, pat_a5);
    check("b2b_q1_second", q1, '0);
    idle();
    check("b2b_q1_third", q1, pat_a5);
    check("b2b_qv0_end", qv0, 1'b0);
    check("b2b_qv1_end", qv1, 1'b1);

    // Reset pulse after ten RUN cycles: outputs clear, contents re-zeroed.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) do_write(6'd3, pat_a5, '0, '0);
      else do_read(6'd3);
    end
    @(negedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    check("rst_ready0", rdy0, 1'b0);
    check("rst_q0", q0, '0);
    check("rst_q1", q1, '0);
    check("rst_qv1", qv1, 1'b0);
    #2 RST_N = 1'b1;
    CEN = 1'b1;
    wait_ready();
    do_read(6'd3);
    idle();
    check("rst_reread_q0", q0, '0);
    idle();
    check("rst_reread_q1", q1, '0);

    // Address 50 is beyond dut1 depth: write dropped, read gives zero with QVALID.
    rnd_d = {$urandom, $urandom, $urandom, $urandom};
    do_write(6'd50, rnd_d, '0, '0);
    do_read(6'd50);
    idle();
    check("oob_q0", q0, rnd_d);
    idle();
    check("oob_qv1", qv1, 1'b1);
    check("oob_q1", q1, '0);
    check("oob_pe1", pe1, 1'b0);
    for (int a = 0; a < 64; a++) do_read(ADDR_W'(a));
    idle();

`ifdef SRAM_PARITY_EN
    do_write(6'd7, pat_a5, '0, '0);
    do_write(6'd8, pat_a5, '0, '0);
    idle();
    dut0.par_mem[7][0] = ~dut0.par_mem[7][0];
    dut1.par_mem[7][0] = ~dut1.par_mem[7][0];
    corr[0][7][0] = 1'b1;
    corr[1][7][0] = 1'b1;
    do_read(6'd7);
    do_read(6'd8);
    check("par_pe0_a7", pe0, 1'b1);
    check("par_qv0_a7", qv0, 1'b1);
    idle();
    check("par_pe0_a8", pe0, 1'b0);
    check("par_pe1_a7", pe1, 1'b1);
    idle();
    check("par_pe1_a8", pe1, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), ADDR_W'($urandom_range(0, 63)),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom},
            LANES1'($urandom));
    end
    idle();
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
